// File: rtl/bcd_to_binary_seq.sv
// ----------------------------------------------------------------------------
// bcd_to_binary_seq : sequential 3-digit BCD to 10-bit binary converter
// Revision 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module bcd_to_binary_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] Centenas,
  input  logic [3:0] Decenas,
  input  logic [3:0] Unidades,
  output logic [9:0] Binario,
  output logic       busy,
  output logic       done,
  output logic       error
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0] LAST_ITER = 4'd9;

  state_t      state_q, state_d;
  logic [21:0] work_q, work_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [9:0]  bin_q, bin_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic        err_pend_q, err_pend_d;

  logic        w_digit_bad;
  logic [21:0] w_shifted;
  logic [21:0] w_iter;

  assign w_digit_bad = (Centenas > 4'd9) || (Decenas > 4'd9) || (Unidades > 4'd9);
  assign w_shifted   = work_q >> 1;

  // Each digit field is corrected in isolation so no borrow crosses fields.
  always_comb begin
    w_iter = w_shifted;
    for (int i = 0; i < 3; i++) begin
      if (w_shifted[10 + 4*i +: 4] >= 4'd8) begin
        w_iter[10 + 4*i +: 4] = w_shifted[10 + 4*i +: 4] - 4'd3;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    work_d     = work_q;
    cnt_d      = cnt_q;
    bin_d      = bin_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    error_d    = error_q;
    err_pend_d = err_pend_q;

    case (state_q)
      IDLE: begin
        // A rejected request waits one IDLE cycle before reporting.
        if (err_pend_q) begin
          err_pend_d = 1'b0;
          bin_d      = 10'd0;
          error_d    = 1'b1;
          done_d     = 1'b1;
          busy_d     = 1'b0;
          state_d    = DONE;
        end else if (start) begin
          work_d = {Centenas, Decenas, Unidades, 10'b0};
          cnt_d  = 4'd0;
          if (w_digit_bad) begin
            err_pend_d = 1'b1;
          end else begin
            busy_d  = 1'b1;
            state_d = SHIFT;
          end
        end
      end

      SHIFT: begin
        work_d = w_iter;
        cnt_d  = cnt_q + 4'd1;
        if (cnt_q == LAST_ITER) begin
          bin_d   = w_iter[9:0];
          done_d  = 1'b1;
          busy_d  = 1'b0;
          error_d = 1'b0;
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      work_q     <= 22'd0;
      cnt_q      <= 4'd0;
      bin_q      <= 10'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      err_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      work_q     <= work_d;
      cnt_q      <= cnt_d;
      bin_q      <= bin_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      err_pend_q <= err_pend_d;
    end
  end

  assign Binario = bin_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign error   = error_q;

endmodule

`default_nettype wire

// File: tb/tb_bcd_to_binary_seq.sv
// ----------------------------------------------------------------------------
// tb_bcd_to_binary_seq : directed self-checking bench for bcd_to_binary_seq
// Revision 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_bcd_to_binary_seq;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] Centenas;
  logic [3:0] Decenas;
  logic [3:0] Unidades;
  logic [9:0] Binario;
  logic       busy;
  logic       done;
  logic       error;

  int n_err;
  int n_chk;

  bcd_to_binary_seq dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .Centenas (Centenas),
    .Decenas  (Decenas),
    .Unidades (Unidades),
    .Binario  (Binario),
    .busy     (busy),
    .done     (done),
    .error    (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Launch one request and watch 14 edges; disturb re-drives 9,9,9 with start mid-run.
  task automatic run_conv(input logic [3:0] c, input logic [3:0] d, input logic [3:0] u,
                          input int exp_bin, input int exp_err, input int exp_lat,
                          input bit disturb, input string tag);
    int lat;
    int nbusy;
    int ndone;
    @(negedge clk);
    Centenas = c; Decenas = d; Unidades = u; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    nbusy = int'(busy);
    lat   = 0;
    ndone = 0;
    for (int i = 1; i <= 14; i++) begin
      @(posedge clk); #1;
      if (busy) nbusy++;
      if (done) begin
        ndone++;
        if (lat == 0) begin
          lat = i;
          check({tag, "_bin"}, int'(Binario), exp_bin);
          check({tag, "_err"}, int'(error), exp_err);
        end
      end
      if (disturb && i == 2) begin
        Centenas = 4'd9; Decenas = 4'd9; Unidades = 4'd9; start = 1'b1;
      end
      if (disturb && i == 3) start = 1'b0;
    end
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_ndone"}, ndone, 1);
    check({tag, "_busycyc"}, nbusy, (exp_err != 0) ? 0 : 10);
    check({tag, "_hold"}, int'(Binario), exp_bin);
  endtask

  initial begin
    int ndone;
    int first;
    int prev;
    int gap_bad;
    n_err = 0; n_chk = 0;
    rst = 1'b1; start = 1'b0;
    Centenas = 4'd0; Decenas = 4'd0; Unidades = 4'd0;
    #1;
    check("rst_bin",   int'(Binario), 0);
    check("rst_busy",  int'(busy),    0);
    check("rst_done",  int'(done),    0);
    check("rst_error", int'(error),   0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;

    run_conv(4'd9, 4'd9, 4'd9, 999, 0, 10, 1'b0, "c999");
    run_conv(4'd0, 4'd0, 4'd0,   0, 0, 10, 1'b0, "c000");
    run_conv(4'd2, 4'd5, 4'd5, 255, 0, 10, 1'b0, "c255");
    run_conv(4'd1, 4'd0, 4'd0, 100, 0, 10, 1'b0, "c100");
    run_conv(4'd1, 4'hA, 4'd3,   0, 1,  1, 1'b0, "c1A3");
    run_conv(4'd1, 4'd2, 4'd3, 123, 0, 10, 1'b1, "c123");

    // Abort a conversion with reset partway through.
    @(negedge clk);
    Centenas = 4'd4; Decenas = 4'd5; Unidades = 4'd6; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_bin",  int'(Binario), 0);
    check("abort_busy", int'(busy),    0);
    check("abort_done", int'(done),    0);
    ndone = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    @(negedge clk); rst = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("abort_nodone", ndone, 0);
    run_conv(4'd0, 4'd4, 4'd2, 42, 0, 10, 1'b0, "c042");

    // start held high for 30 edges: back-to-back conversions every 12 cycles.
    @(negedge clk);
    Centenas = 4'd7; Decenas = 4'd8; Unidades = 4'd9; start = 1'b1;
    @(posedge clk); #1;
    ndone = 0; first = 0; prev = 0; gap_bad = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (i == 29) start = 1'b0;
      if (done) begin
        ndone++;
        check("b2b_bin", int'(Binario), 789);
        if (first == 0) first = i;
        else if (i - prev != 12) gap_bad++;
        prev = i;
      end
    end
    check("b2b_first", first, 10);
    check("b2b_count", ndone, 3);
    check("b2b_gap",   gap_bad, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
